// File: rtl/stereo_window_streamer.sv
// ----------------------------------------------------------------------------
// stereo_window_streamer
//   Transmitter side of the 5x5 stereo window interface. Takes one left/right
//   pixel pair per accepted cycle from a raster stream. Keeps the last four
//   lines per eye and emits a registered 5x5 window pair for every pixel
//   position that has a full window behind it.
//
// Ports
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_valid             pixel pair present (no backpressure)
//   i_sof               start of frame, qualified by i_valid; forces (0,0)
//   i_pixel_l/_r        8-bit left / right pixel
//   o_valid             one-cycle window strobe, one clock after trigger
//   o_window_l/_r       5x5 window, [row][col]; [4][4] = newest pixel
//   o_frame_done        strobe with the last window of a frame
//   o_center_x/_y       (WIN_COORD_EN only) window centre (col-2, row-2)
//
// Optional feature macro: WIN_COORD_EN
// ----------------------------------------------------------------------------
module stereo_window_streamer #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_valid,
    input  logic                      i_sof,
    input  logic [7:0]                i_pixel_l,
    input  logic [7:0]                i_pixel_r,
    output logic                      o_valid,
    output logic [4:0][4:0][7:0]      o_window_l,
    output logic [4:0][4:0][7:0]      o_window_r,
`ifdef WIN_COORD_EN
    output logic [$clog2(IMG_W)-1:0]  o_center_x,
    output logic [$clog2(IMG_H)-1:0]  o_center_y,
`endif
    output logic                      o_frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_4    = CW'(4);
    localparam logic [RW-1:0] ROW_4    = RW'(4);

    // One line-buffer entry holds a column of the four stored lines;
    // index 0 is the oldest line, index 3 the newest.
    typedef logic [3:0][7:0] lbcol_t;

    lbcol_t lb_l_q [IMG_W];
    lbcol_t lb_r_q [IMG_W];

    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    lbcol_t        rd_l, rd_r;
    logic          hit, last;

    logic [4:0][4:0][7:0] win_l_q, win_l_d, win_r_q, win_r_d;
    logic                 valid_q, valid_d, done_q, done_d;

    always_comb begin
        // An accepted sof re-synchronises the stream to (0,0) on this pixel.
        cur_col = i_sof ? '0 : col_q;
        cur_row = i_sof ? '0 : row_q;
        rd_l    = lb_l_q[cur_col];
        rd_r    = lb_r_q[cur_col];
        hit     = (cur_row >= ROW_4) && (cur_col >= COL_4);
        last    = (cur_row == ROW_LAST) && (cur_col == COL_LAST);

        col_d   = col_q;
        row_d   = row_q;
        win_l_d = win_l_q;
        win_r_d = win_r_q;
        valid_d = 1'b0;
        done_d  = 1'b0;

        if (i_valid) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end

            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 4; c++) begin
                    win_l_d[r][c] = win_l_q[r][c+1];
                    win_r_d[r][c] = win_r_q[r][c+1];
                end
            end
            for (int r = 0; r < 4; r++) begin
                win_l_d[r][4] = rd_l[r];
                win_r_d[r][4] = rd_r[r];
            end
            win_l_d[4][4] = i_pixel_l;
            win_r_d[4][4] = i_pixel_r;

            // Rows 0-3 of a frame never flag valid, which also keeps any
            // previous-frame lines still in the buffers out of valid windows.
            valid_d = hit;
            done_d  = hit & last;
        end
    end

    // Line buffers: read above is combinational, so the write below sees the
    // pre-write column (read-before-write). Contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (i_valid) begin
            lb_l_q[cur_col] <= {i_pixel_l, rd_l[3:1]};
            lb_r_q[cur_col] <= {i_pixel_r, rd_r[3:1]};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            win_l_q <= '0;
            win_r_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            win_l_q <= win_l_d;
            win_r_q <= win_r_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_frame_done = done_q;
    assign o_window_l   = win_l_q;
    assign o_window_r   = win_r_q;

`ifdef WIN_COORD_EN
    logic [CW-1:0] cx_q, cx_d;
    logic [RW-1:0] cy_q, cy_d;

    // Centre coordinates only move when a window is produced.
    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (i_valid && hit) begin
            cx_d = cur_col - CW'(2);
            cy_d = cur_row - RW'(2);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

    assign o_center_x = cx_q;
    assign o_center_y = cy_q;
`endif

endmodule
